// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encodings, default rates and control-FSM helpers for the stopwatch lab
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_t;

   localparam int CLK_FREQ_HZ_DEF = 100_000_000;
   localparam int TICK_HZ_DEF     = 10;
   localparam int TICK_DIV_DEF    = CLK_FREQ_HZ_DEF / TICK_HZ_DEF;

   function automatic int tick_div(input int clk_freq_hz, input int tick_hz);
      return clk_freq_hz / tick_hz;
   endfunction

   function automatic logic is_counting(input state_t s);
      return s == ST_RUN || s == ST_LAP;
   endfunction

   // Clear beats startstop beats lap; the losing pulses of that cycle are dropped.
   function automatic state_t next_state(input state_t s, input logic ss, input logic clr, input logic lap);
      return clr ? ST_IDLE :
             ss  ? (is_counting(s) ? ST_PAUSE : ST_RUN) :
             !lap ? s :
             s == ST_RUN ? ST_LAP :
             s == ST_LAP ? ST_RUN : s;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: enable-gated modulo-DIV counter emitting a registered one-cycle pulse after each wrap
module tick_prescaler #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = DIV > 1 ? $clog2(DIV) : 1;

   logic [W-1:0] cnt;
   logic         tc;

   assign tc = en && cnt == W'(DIV - 1);

   // Count while enabled, hold otherwise; clear wins over a coincident wrap and suppresses its tick.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= tc;
         if (en) cnt <= tc ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap control FSM and count-tick scheduler; lap support enabled by STOPWATCH_LAP_EN
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
   parameter int TICK_HZ     = TICK_HZ_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_startstop,
   input  logic       btn_clear,
   input  logic       btn_lap,
   output logic       tick_en,
   output logic       time_clr,
   output logic       disp_hold,
   output logic       running,
   output logic [1:0] state
);

   localparam int TICK_DIV = tick_div(CLK_FREQ_HZ, TICK_HZ);

   state_t st, nxt;
   logic   lap;

`ifdef STOPWATCH_LAP_EN
   assign lap = btn_lap;
`else
   logic lap_unused;
   assign lap_unused = btn_lap;
   assign lap        = 1'b0;
`endif

   assign nxt   = next_state(st, btn_startstop, btn_clear, lap);
   assign state = st;

   // Control FSM; outputs are registered from the next state so they change on the same edge as state.
   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= ST_IDLE;
         time_clr  <= 1'b0;
         disp_hold <= 1'b0;
         running   <= 1'b0;
      end else begin
         st        <= nxt;
         time_clr  <= btn_clear;
         disp_hold <= nxt == ST_LAP;
         running   <= is_counting(nxt);
      end
   end

   tick_prescaler #(.DIV(TICK_DIV)) u_presc (
      .clk   (clk),
      .reset (reset),
      .en    (is_counting(st)),
      .clr   (btn_clear),
      .tick  (tick_en)
   );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed vectors for stopwatch_ctrl with TICK_DIV=10
module tb_stopwatch_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_startstop = 1'b0;
   logic       btn_clear = 1'b0;
   logic       btn_lap = 1'b0;
   logic       tick_en, time_clr, disp_hold, running;
   logic [1:0] state;
   int         nvec = 0;
   int         nerr = 0;
   logic [63:0] m;

   stopwatch_ctrl #(.CLK_FREQ_HZ(10), .TICK_HZ(1)) dut (
      .clk           (clk),
      .reset         (reset),
      .btn_startstop (btn_startstop),
      .btn_clear     (btn_clear),
      .btn_lap       (btn_lap),
      .tick_en       (tick_en),
      .time_clr      (time_clr),
      .disp_hold     (disp_hold),
      .running       (running),
      .state         (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic ss, input logic clr, input logic lap);
      btn_startstop = ss;
      btn_clear     = clr;
      btn_lap       = lap;
      step();
      btn_startstop = 1'b0;
      btn_clear     = 1'b0;
      btn_lap       = 1'b0;
   endtask

   // bit k-1 of mask is tick_en after the k-th edge
   task automatic run(input int n, output logic [63:0] mask);
      mask = '0;
      for (int k = 0; k < n; k++) begin
         step();
         mask[k] = tick_en;
      end
   endtask

   task automatic chk_outs(input string tag, input int st, input logic run_l, input logic hold, input logic clr);
      chk({tag, "_state"}, 64'(state), 64'(st));
      chk({tag, "_running"}, 64'(running), 64'(run_l));
      chk({tag, "_hold"}, 64'(disp_hold), 64'(hold));
      chk({tag, "_clr"}, 64'(time_clr), 64'(clr));
   endtask

   initial begin
      step();
      step();
      reset = 1'b0;
      chk_outs("reset", 0, 0, 0, 0);
      chk("reset_tick", 64'(tick_en), 0);

      press(1, 0, 0);
      chk_outs("start", 1, 1, 0, 0);
      run(30, m);
      chk("start_ticks", m, 64'h2008_0200);

      press(0, 1, 0);
      chk_outs("clear", 0, 0, 0, 1);
      chk("clear_tick", 64'(tick_en), 0);
      step();
      chk("clear_pulse_end", 64'(time_clr), 0);

      press(1, 0, 0);
      run(14, m);
      chk("pre_pause_ticks", m, 64'h200);
      press(1, 0, 0);
      chk_outs("pause", 2, 0, 0, 0);
      run(50, m);
      chk("pause_ticks", m, 0);
      press(1, 0, 0);
      chk_outs("resume", 1, 1, 0, 0);
      run(10, m);
      chk("resume_ticks", m, 64'h10);

      press(1, 1, 1);
      chk_outs("multi", 0, 0, 0, 1);
      step();
      chk("multi_clr_end", 64'(time_clr), 0);
      run(20, m);
      chk("idle_ticks", m, 0);
      press(1, 0, 0);
      run(10, m);
      chk("restart_ticks", m, 64'h200);

      press(0, 0, 1);
`ifdef STOPWATCH_LAP_EN
      chk_outs("lap_on", 3, 1, 1, 0);
`else
      chk_outs("lap_on", 1, 1, 0, 0);
`endif
      run(10, m);
      chk("lap_ticks", m, 64'h100);
      press(0, 0, 1);
      chk_outs("lap_off", 1, 1, 0, 0);
      press(0, 0, 1);
      press(1, 0, 0);
      chk_outs("lap_pause", 2, 0, 0, 0);

      press(1, 0, 0);
      run(5, m);
      chk("tc_ss_pre", m, 0);
      press(1, 0, 0);
      chk("tc_ss_tick", 64'(tick_en), 1);
      chk("tc_ss_state", 64'(state), 2);
      step();
      chk("tc_ss_tick_end", 64'(tick_en), 0);

      press(1, 0, 0);
      run(9, m);
      chk("tc_clr_pre", m, 0);
      press(0, 1, 0);
      chk("tc_clr_tick", 64'(tick_en), 0);
      chk_outs("tc_clr", 0, 0, 0, 1);

      btn_clear = 1'b1;
      step();
      chk("rep_clr_a", 64'(time_clr), 1);
      step();
      chk("rep_clr_b", 64'(time_clr), 1);
      btn_clear = 1'b0;
      step();
      chk("rep_clr_end", 64'(time_clr), 0);

      press(1, 0, 0);
      run(3, m);
      reset = 1'b1;
      press(1, 0, 0);
      reset = 1'b0;
      chk_outs("mid_reset", 0, 0, 0, 0);
      chk("mid_reset_tick", 64'(tick_en), 0);
      run(15, m);
      chk("post_reset_ticks", m, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
